// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed instruction store with async fetch read and sync load/clear
module instruction_memory #(
    parameter int PC_WIDTH = 9,
    parameter int NB_WIDTH = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_write_enable,
    input  logic [PC_WIDTH-1:0] i_address,
    input  logic [NB_WIDTH-1:0] write_register,
    output logic [NB_WIDTH-1:0] o_instruction
);

    localparam int DEPTH = 2 ** PC_WIDTH;

    logic [NB_WIDTH-1:0] mem [DEPTH];

    // Reset wipes the whole array in one edge and wins over a same-edge load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_write_enable) begin
            mem[i_address] <= write_register;
        end
    end

    // Fetch read is combinational; no bypass, so a same-address write shows only after the edge.
    assign o_instruction = mem[i_address];

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed self-checking bench for instruction_memory
module tb_instruction_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [8:0]  address;
    logic [31:0] write_data;
    logic [31:0] instruction;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [8:0]  vec_addr [10] = '{9'd7, 9'd123, 9'd200, 9'd301, 9'd17,
                                   9'd450, 9'd88, 9'd255, 9'd256, 9'd399};
    logic [31:0] vec_data [10] = '{32'hC0895E81, 32'h8484D609, 32'hB1F05663, 32'h06B97B0D,
                                   32'h46DF998D, 32'hB2C28465, 32'h89375212, 32'h00F3E301,
                                   32'h06D7CD0D, 32'h3B23F176};

    instruction_memory #(
        .PC_WIDTH(9),
        .NB_WIDTH(32)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_write_enable (write_enable),
        .i_address      (address),
        .write_register (write_data),
        .o_instruction  (instruction)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge so the rising edge sees them stable.
    task automatic write_word(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        write_enable = 1'b0;
        address      = 9'd36;
        write_data   = '0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_addr36", instruction, 32'h0);

        write_word(9'd36, 32'h12153524);
        #1 check("basic_write_36", instruction, 32'h12153524);

        @(negedge clk);
        address      = 9'd5;
        write_data   = 32'hDEADBEEF;
        write_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("we_low_addr5", instruction, 32'h0);

        address      = 9'd36;
        write_data   = 32'h0BADCAFE;
        write_enable = 1'b1;
        #1 check("rdw_old_before_edge", instruction, 32'h12153524);
        @(posedge clk);
        #1 check("rdw_new_after_edge", instruction, 32'h0BADCAFE);
        @(negedge clk);
        write_enable = 1'b0;

        for (int i = 0; i < 10; i++) begin
            write_word(vec_addr[i], vec_data[i]);
            #1 check($sformatf("vec_write_%0d", i), instruction, vec_data[i]);
        end

        address = vec_addr[0];
        #1 check("pre_reset_readback_0", instruction, vec_data[0]);

        @(negedge clk);
        address = vec_addr[9];
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_clear_last", instruction, 32'h0);
        for (int i = 0; i < 10; i += 3) begin
            address = vec_addr[i];
            #1 check($sformatf("reset_sweep_%0d", i), instruction, 32'h0);
        end
        address = 9'd36;
        #1 check("reset_sweep_36", instruction, 32'h0);

        @(negedge clk);
        address      = 9'd100;
        write_data   = 32'hCAFEF00D;
        write_enable = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        reset        = 1'b0;
        #1 check("reset_beats_write", instruction, 32'h0);

        write_word(9'd100, 32'h13579BDF);
        #1 check("load_after_reset", instruction, 32'h13579BDF);

        write_word(9'd0, 32'hAAAAAAAA);
        write_word(9'd511, 32'h55555555);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            address = 9'd0;
            #1 check($sformatf("async_addr0_%0d", i), instruction, 32'hAAAAAAAA);
            address = 9'd511;
            #1 check($sformatf("async_addr511_%0d", i), instruction, 32'h55555555);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
